reset_mux_sync: RTL
===================

# reset_mux_sync

Parametrised N-way reset selector, successor to the two-input registered reset mux. It routes one of `NUM_RST` active-low reset inputs to a single reset output under a registered selector. A selector change runs a hold sequence that keeps the output asserted for a programmable number of cycles, so downstream logic never sees a glitch or a partial deassertion during switchover. It sits between the clock/reset generation domain and any sub-system whose reset source is chosen at run time.

## Interface
Parameters:
- `NUM_RST`, 4: number of reset inputs; must be ≥2.
- `SEL_W`, 2: selector width; must be ≥ clog2(`NUM_RST`).
- `HOLD_CYCLES`, 4: number of cycles the output is forced asserted on switchover; must be ≥1 and < 2^16.
- `INIT_SEL`, 0: selector value after reset; must be < `NUM_RST`.

Ports:
- `CLK`  input  1  sole clock; all state on rising edge.
- `RST_N`  input  1  asynchronous, active-low block reset.
- `SELECT`  input  SEL_W  requested reset source index.
- `SELECT_ENABLE`  input  1  request strobe; `SELECT` is sampled when this is high.
- `RST_IN`  input  NUM_RST  bit i is active-low reset source i.
- `RST_OUT`  output  1  active-low selected reset.
- `SEL_CUR`  output  SEL_W  currently applied selector (registered).
- `BUSY`  output  1  high while a switchover hold is in progress.
- `SEL_ERR`  output  1  one-cycle pulse on a rejected out-of-range request.

## Operation
- State: `sel_reg` (SEL_W), `pend_reg` (SEL_W), a 16-bit down-counter `hold_cnt`, an FSM {IDLE, HOLD}, and `err_reg`.
- Async reset (`RST_N`=0) forces: FSM=IDLE, `sel_reg`=`INIT_SEL`, `hold_cnt`=0, `err_reg`=0. `RST_OUT`=0 while `RST_N`=0, regardless of the inputs.
- Reset values of outputs: `SEL_CUR`=`INIT_SEL`, `BUSY`=0, `SEL_ERR`=0, `RST_OUT`=0.
- IDLE behaviour:
  - Raw output is `RST_IN[sel_reg]`.
  - Request in range and not equal to `sel_reg`: `pend_reg`←`SELECT`, `hold_cnt`←`HOLD_CYCLES`−1, FSM→HOLD.
  - Request equal to `sel_reg`: no-op; no hold is run and `BUSY` stays 0.
  - Request with `SELECT` ≥ `NUM_RST`: ignored; `err_reg`←1 for exactly one cycle.
- HOLD behaviour:
  - Raw output is forced to 0. `BUSY`=1.
  - `hold_cnt` decrements each cycle.
  - When `hold_cnt`==0: `sel_reg`←`pend_reg`, FSM→IDLE.
  - `SELECT_ENABLE` during HOLD is ignored silently: no error and no queuing.
- Transitions of the unselected `RST_IN` bits never affect `RST_OUT`.
- `RST_N` asserted mid-HOLD aborts the switchover. `SEL_CUR` returns to `INIT_SEL`; it does not take the pending value.

## Timing
- Request sampled at edge k, where k is the first rising edge with `SELECT_ENABLE`=1:
  - `BUSY`=1 and `RST_OUT`=0 from just after edge k.
  - Exactly `HOLD_CYCLES` cycles later (edge k+`HOLD_CYCLES`), `SEL_CUR` shows the new value and `BUSY` falls.
  - The raw output then follows the new source (combinational path, or the synchronised path when `RESET_MUX_SYNC_EN` is set).
- `SEL_ERR` is high for the single cycle after the sampling edge.
- IDLE with no change: `RST_OUT` follows `RST_IN[sel_reg]` combinationally (zero latency) when the sync feature is off.
- A new request is accepted on the same edge that `BUSY` falls? No. It is accepted from the first edge at which `BUSY` is already 0.

## Configuration
- `RESET_MUX_SYNC_EN` defined:
  - The raw output (already gated by `RST_N` and HOLD) drives the async clear of a 2-flop synchroniser clocked by `CLK`. `RST_OUT` is the second flop.
  - Assertion is immediate (asynchronous). Deassertion takes 2 rising edges after the raw value goes high.
  - After HOLD ends, `RST_OUT` deasserts 2 edges after `BUSY` falls, provided the new source is deasserted.
- `RESET_MUX_SYNC_EN` undefined:
  - No synchroniser. `RST_OUT` = `RST_N` & ~HOLD & `RST_IN[sel_reg]`, combinationally.

## Test plan
- Apply reset with `INIT_SEL`=0 and `RST_IN`=4'b1111, then release `RST_N`:
  - `SEL_CUR`=0, `BUSY`=0, `RST_OUT`=1 (sync build: after 2 edges).
  - Toggle `RST_IN[0]` low: `RST_OUT` goes 0 immediately. Toggling `RST_IN[2]` has no effect.
- Request `SELECT`=2 with `HOLD_CYCLES`=4 and all inputs high:
  - `BUSY`=1 and `RST_OUT`=0 for exactly 4 cycles.
  - `SEL_CUR`=2 on the 4th edge.
  - Then `RST_OUT`=1 immediately (no-sync build) or 2 edges later (sync build).
- Request `SELECT`=`SEL_CUR`: no `BUSY`, no `RST_OUT` dip, `SEL_ERR`=0.
- With `NUM_RST`=3 and `SEL_W`=2, request `SELECT`=3:
  - `SEL_ERR` pulses for 1 cycle; `SEL_CUR` and `RST_OUT` are unchanged.
- Strobe `SELECT`=1 during HOLD toward 2: ignored; the final `SEL_CUR`=2.
- Assert `RST_N` in the 2nd HOLD cycle:
  - `RST_OUT`=0 immediately; `BUSY`=0 and `SEL_CUR`=`INIT_SEL`.
  - After release, no residual hold occurs.

Source files
------------

// File: rtl/reset_mux_sync.sv
// reset_mux_sync: N-way active-low reset selector with a glitch-free switchover hold.
// A selector change forces the output asserted for HOLD_CYCLES cycles before the
// new source is applied. Optional macro RESET_MUX_SYNC_EN adds a 2-flop
// reset synchroniser (async assert, sync deassert) on the output.
module reset_mux_sync #(
  parameter int unsigned NUM_RST     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned INIT_SEL    = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [SEL_W-1:0]   SELECT,
  input  logic               SELECT_ENABLE,
  input  logic [NUM_RST-1:0] RST_IN,
  output logic               RST_OUT,
  output logic [SEL_W-1:0]   SEL_CUR,
  output logic               BUSY,
  output logic               SEL_ERR
);

  localparam int unsigned PAD_W  = 1 << SEL_W;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_INIT    = SEL_W'(INIT_SEL);
  localparam logic [SEL_W:0]   SEL_LIMIT   = (SEL_W + 1)'(NUM_RST);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   sel_reg;
  logic [SEL_W-1:0]   pend_reg;
  logic [CNT_W-1:0]   hold_cnt;
  logic               err_reg;

  logic [PAD_W-1:0]   rst_in_pad;
  logic               sel_in_range;
  logic               raw_rst_n;

  // Zero-extend the source vector so any selector code indexes a real bit.
  assign rst_in_pad   = PAD_W'(RST_IN);
  assign sel_in_range = {1'b0, SELECT} < SEL_LIMIT;

  // Selector FSM: accept requests in IDLE, count down the hold, then apply.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sel_reg  <= SEL_INIT;
      pend_reg <= SEL_INIT;
      hold_cnt <= '0;
      err_reg  <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_q)
        IDLE: begin
          if (SELECT_ENABLE) begin
            if (!sel_in_range) begin
              err_reg <= 1'b1;
            end else if (SELECT != sel_reg) begin
              pend_reg <= SELECT;
              hold_cnt <= HOLD_RELOAD;
              state_q  <= HOLD;
            end
          end
        end
        HOLD: begin
          // Requests arriving here are dropped on purpose: no queuing, no error.
          if (hold_cnt == '0) begin
            sel_reg <= pend_reg;
            state_q <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SEL_CUR = sel_reg;
  assign BUSY    = (state_q == HOLD);
  assign SEL_ERR = err_reg;

  // Raw reset: block reset, switchover hold and the selected source, all active-low.
  assign raw_rst_n = RST_N & (state_q != HOLD) & rst_in_pad[sel_reg];

`ifdef RESET_MUX_SYNC_EN
  logic [1:0] sync_q;

  // Reset synchroniser: raw low clears immediately, release ripples through 2 flops.
  always_ff @(posedge CLK or negedge raw_rst_n) begin
    if (!raw_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign RST_OUT = sync_q[1];
`else
  assign RST_OUT = raw_rst_n;
`endif

endmodule
